// File: rtl/arp_server_subnet_top_hls_deadlock_report_unit_pkg.sv
// Shared definitions for the deadlock report unit: FSM state encoding,
// default sizing constants and the process-ID width helper.
package arp_server_subnet_top_hls_deadlock_report_unit_pkg;

  localparam int PROC_NUM_DEFAULT  = 4;
  localparam int TRACE_MAX_DEFAULT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_TRACE,
    ST_REPORT,
    ST_DONE
  } dl_state_t;

  // A single monitored process still needs a one-bit ID field.
  function automatic int calc_id_w(input int proc_num);
    return (proc_num > 1) ? $clog2(proc_num) : 1;
  endfunction

endpackage

// File: rtl/arp_server_subnet_top_hls_deadlock_report_unit_if.sv
// Valid/ready stream carrying the IDs of the deadlocked processes.
interface arp_server_subnet_top_hls_deadlock_report_unit_if
  import arp_server_subnet_top_hls_deadlock_report_unit_pkg::*;
#(
  parameter int ID_W = calc_id_w(PROC_NUM_DEFAULT)
);

  logic            rpt_valid;
  logic            rpt_ready;
  logic [ID_W-1:0] rpt_id;
  logic            rpt_last;

  modport master (
    output rpt_valid,
    output rpt_id,
    output rpt_last,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_id,
    input  rpt_last,
    output rpt_ready
  );

endinterface

// File: rtl/arp_server_subnet_top_hls_deadlock_mask_walker.sv
// Registered lowest-set-bit iterator over the captured deadlock mask.
// A load pulse snapshots the mask; each accepted beat retires the lowest
// remaining bit and the next one is presented on the following cycle.
module arp_server_subnet_top_hls_deadlock_mask_walker
  import arp_server_subnet_top_hls_deadlock_report_unit_pkg::*;
#(
  parameter int PROC_NUM = PROC_NUM_DEFAULT,
  parameter int ID_W     = calc_id_w(PROC_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [PROC_NUM-1:0] load_mask,
  output logic                done,
  arp_server_subnet_top_hls_deadlock_report_unit_if.master rpt
);

  // Bits still to be reported; the lowest one is the beat on the port.
  logic [PROC_NUM-1:0] remain_q;
  logic                valid_q;
  logic [ID_W-1:0]     id_q;
  logic                last_q;

  logic                accept;
  logic [PROC_NUM-1:0] src_mask;
  logic [ID_W-1:0]     next_id;
  logic                next_last;

  function automatic logic [ID_W-1:0] lowest_index(input logic [PROC_NUM-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  assign accept = valid_q & rpt.rpt_ready;
  assign done   = accept & last_q;

  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_id    = id_q;
  assign rpt.rpt_last  = last_q;

  // Pick the mask the next beat is drawn from: a fresh snapshot on load, or
  // the remaining bits with the just-accepted (lowest) bit cleared.
  always_comb begin
    src_mask = remain_q;
    if (load) begin
      src_mask = load_mask;
    end else if (accept) begin
      src_mask = remain_q & (remain_q - PROC_NUM'(1));
    end
    next_id   = lowest_index(src_mask);
    next_last = (src_mask & (src_mask - PROC_NUM'(1))) == '0;
  end

  // Beat registers only move on load or handshake, so a stalled beat holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      remain_q <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      last_q   <= 1'b0;
    end else if (load || accept) begin
      remain_q <= src_mask;
      valid_q  <= |src_mask;
      id_q     <= next_id;
      last_q   <= (|src_mask) & next_last;
    end
  end

endmodule

// File: rtl/arp_server_subnet_top_hls_deadlock_report_unit.sv
// Deadlock report unit: elects an origin among detecting processes, launches
// the report token, traces it around the dependency cycle, then streams the
// IDs of every process that held the token. Results stay sticky until ack.
module arp_server_subnet_top_hls_deadlock_report_unit
  import arp_server_subnet_top_hls_deadlock_report_unit_pkg::*;
#(
  parameter int PROC_NUM  = PROC_NUM_DEFAULT,
  parameter int ID_W      = calc_id_w(PROC_NUM),
  parameter int TRACE_MAX = TRACE_MAX_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_vec,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                dl_flag,
  output logic                dl_timeout,
  output logic [PROC_NUM-1:0] dl_mask,
  input  logic                ack,
  arp_server_subnet_top_hls_deadlock_report_unit_if.master rpt
);

  localparam int CNT_W = $clog2(TRACE_MAX) + 1;

  dl_state_t           state;
  logic [PROC_NUM-1:0] org_onehot;
  logic [PROC_NUM-1:0] det_onehot;
  logic [CNT_W-1:0]    trace_cnt;
  logic                report_loaded;
  logic                token_home;
  logic                walker_load;
  logic                walker_done;

  // Lowest-index detecting process wins the election (two's-complement isolate).
  assign det_onehot  = dl_detect_vec & (~dl_detect_vec + PROC_NUM'(1));
  assign token_home  = |(token_vec & org_onehot);
  assign token_clear = (state == ST_TRACE) && token_home;
  assign walker_load = (state == ST_REPORT) && !report_loaded;

  // Main control FSM; origin pulse and sticky results are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      org_onehot    <= '0;
      origin        <= '0;
      dl_flag       <= 1'b0;
      dl_timeout    <= 1'b0;
      dl_mask       <= '0;
      trace_cnt     <= '0;
      report_loaded <= 1'b0;
    end else begin
      origin <= '0;
      case (state)
        ST_IDLE: begin
          if (|dl_detect_vec) begin
            org_onehot <= det_onehot;
            dl_mask    <= det_onehot;
            dl_flag    <= 1'b1;
            origin     <= det_onehot;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          trace_cnt <= '0;
          state     <= ST_TRACE;
        end
        ST_TRACE: begin
          dl_mask   <= dl_mask | token_vec;
          trace_cnt <= trace_cnt + CNT_W'(1);
          if (token_home) begin
            report_loaded <= 1'b0;
            state         <= ST_REPORT;
          end else if (trace_cnt == CNT_W'(TRACE_MAX - 1)) begin
            dl_timeout    <= 1'b1;
            report_loaded <= 1'b0;
            state         <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          report_loaded <= 1'b1;
          if (walker_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ack) begin
            dl_flag    <= 1'b0;
            dl_timeout <= 1'b0;
            dl_mask    <= '0;
            org_onehot <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  arp_server_subnet_top_hls_deadlock_mask_walker #(
    .PROC_NUM (PROC_NUM),
    .ID_W     (ID_W)
  ) u_walker (
    .clock     (clock),
    .reset     (reset),
    .load      (walker_load),
    .load_mask (dl_mask),
    .done      (walker_done),
    .rpt       (rpt)
  );

endmodule

// File: tb/tb_arp_server_subnet_top_hls_deadlock_report_unit.sv
// Self-checking bench for the deadlock report unit. Each scenario derives
// the elected origin, token-return cycle, final mask and beat list directly
// from the detect vector and the token sequence, then drives the DUT.
module tb_arp_server_subnet_top_hls_deadlock_report_unit;

  localparam int PROC_NUM  = 4;
  localparam int ID_W      = 2;
  localparam int TRACE_MAX = 64;

  logic                clock = 1'b0;
  logic                reset;
  logic [PROC_NUM-1:0] dl_detect_vec;
  logic [PROC_NUM-1:0] token_vec;
  logic [PROC_NUM-1:0] origin;
  logic                token_clear;
  logic                dl_flag;
  logic                dl_timeout;
  logic [PROC_NUM-1:0] dl_mask;
  logic                ack;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [PROC_NUM-1:0] tok_q[$];
  int                  ret_idx;

  arp_server_subnet_top_hls_deadlock_report_unit_if #(.ID_W(ID_W)) rpt_bus ();

  arp_server_subnet_top_hls_deadlock_report_unit #(
    .PROC_NUM  (PROC_NUM),
    .ID_W      (ID_W),
    .TRACE_MAX (TRACE_MAX)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dl_detect_vec (dl_detect_vec),
    .token_vec     (token_vec),
    .origin        (origin),
    .token_clear   (token_clear),
    .dl_flag       (dl_flag),
    .dl_timeout    (dl_timeout),
    .dl_mask       (dl_mask),
    .ack           (ack),
    .rpt           (rpt_bus)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic toDrivePoint();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] lowestOnehot(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 4'(1 << i);
    end
    return 4'b0;
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_origin"}, 32'(origin), 32'd0);
    checkOutput({tag, "_token_clear"}, 32'(token_clear), 32'd0);
    checkOutput({tag, "_dl_flag"}, 32'(dl_flag), 32'd0);
    checkOutput({tag, "_dl_timeout"}, 32'(dl_timeout), 32'd0);
    checkOutput({tag, "_dl_mask"}, 32'(dl_mask), 32'd0);
    checkOutput({tag, "_rpt_valid"}, 32'(rpt_bus.rpt_valid), 32'd0);
    checkOutput({tag, "_rpt_id"}, 32'(rpt_bus.rpt_id), 32'd0);
    checkOutput({tag, "_rpt_last"}, 32'(rpt_bus.rpt_last), 32'd0);
  endtask

  // Random token sequence of len entries; only entry ret carries the origin bit
  // (ret < 0 means the token never returns).
  task automatic buildTokens(input logic [3:0] det, input int ret, input int len);
    logic [3:0] org;
    logic [3:0] t;
    org = lowestOnehot(det);
    tok_q.delete();
    for (int k = 0; k < len; k++) begin
      t = 4'($urandom_range(0, 15));
      if (k == ret) t = t | org;
      else          t = t & ~org;
      tok_q.push_back(t);
    end
    ret_idx = ret;
  endtask

  // One full detect / launch / trace / report / ack pass against tok_q.
  task automatic applyStimulus(input logic [3:0] det, input bit rand_ready, input int stall_beat,
                               input int stall_len, input int abort_after, input logic [3:0] ack_det);
    logic [3:0] exp_org;
    logic [3:0] exp_mask;
    bit         exp_to;
    bit         pending;
    int         n_trace;
    int         idx;
    int         stall;
    int         budget;
    int         exp_ids[$];

    exp_org  = lowestOnehot(det);
    exp_to   = (ret_idx < 0);
    n_trace  = exp_to ? TRACE_MAX : ret_idx + 1;
    exp_mask = exp_org;
    for (int k = 0; k < n_trace; k++) exp_mask = exp_mask | tok_q[k];
    for (int i = 0; i < 4; i++) begin
      if (exp_mask[i]) exp_ids.push_back(i);
    end

    dl_detect_vec     = det;
    token_vec         = 4'($urandom);
    ack               = 1'b0;
    rpt_bus.rpt_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    checkOutput("idle_flag", 32'(dl_flag), 32'd0);
    checkOutput("idle_timeout", 32'(dl_timeout), 32'd0);
    checkOutput("idle_mask", 32'(dl_mask), 32'd0);
    checkOutput("idle_origin", 32'(origin), 32'd0);
    checkOutput("idle_valid", 32'(rpt_bus.rpt_valid), 32'd0);

    toDrivePoint();
    dl_detect_vec = 4'($urandom);
    @(negedge clock);
    checkOutput("launch_origin", 32'(origin), 32'(exp_org));
    checkOutput("launch_mask", 32'(dl_mask), 32'(exp_org));
    checkOutput("launch_flag", 32'(dl_flag), 32'd1);
    checkOutput("launch_clear", 32'(token_clear), 32'd0);

    for (int k = 0; k < n_trace; k++) begin
      toDrivePoint();
      token_vec = tok_q[k];
      @(negedge clock);
      checkOutput("trace_clear", 32'(token_clear), 32'(k == ret_idx));
      checkOutput("trace_origin", 32'(origin), 32'd0);
    end

    toDrivePoint();
    token_vec = 4'($urandom);
    idx     = 0;
    stall   = 0;
    budget  = 0;
    pending = 1'b0;
    while (idx < exp_ids.size() && budget < 300) begin
      if (abort_after > 0 && idx == abort_after) begin
        reset = 1'b0;
        @(negedge clock);
        checkAllZero("abort");
        toDrivePoint();
        reset = 1'b1;
        return;
      end
      if (idx == stall_beat && stall < stall_len) rpt_bus.rpt_ready = 1'b0;
      else rpt_bus.rpt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      dl_detect_vec = 4'($urandom);
      token_vec     = 4'($urandom);
      @(negedge clock);
      if (pending) checkOutput("valid_held", 32'(rpt_bus.rpt_valid), 32'd1);
      if (rpt_bus.rpt_valid) begin
        checkOutput("rpt_id", 32'(rpt_bus.rpt_id), 32'(exp_ids[idx]));
        checkOutput("rpt_last", 32'(rpt_bus.rpt_last), 32'(idx == exp_ids.size() - 1));
        if (rpt_bus.rpt_ready) idx++;
        else if (idx == stall_beat) stall++;
      end
      pending = rpt_bus.rpt_valid && !rpt_bus.rpt_ready;
      budget++;
      toDrivePoint();
    end
    checkOutput("report_beats", 32'(idx), 32'(exp_ids.size()));

    dl_detect_vec     = 4'($urandom_range(1, 15));
    rpt_bus.rpt_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    checkOutput("done_valid", 32'(rpt_bus.rpt_valid), 32'd0);
    checkOutput("done_flag", 32'(dl_flag), 32'd1);
    checkOutput("done_timeout", 32'(dl_timeout), 32'(exp_to));
    checkOutput("done_mask", 32'(dl_mask), 32'(exp_mask));
    checkOutput("done_origin", 32'(origin), 32'd0);
    toDrivePoint();
    @(negedge clock);
    checkOutput("done_hold_flag", 32'(dl_flag), 32'd1);
    checkOutput("done_hold_mask", 32'(dl_mask), 32'(exp_mask));
    checkOutput("done_hold_origin", 32'(origin), 32'd0);
    toDrivePoint();
    ack           = 1'b1;
    dl_detect_vec = ack_det;
    @(negedge clock);
    checkOutput("ack_cycle_flag", 32'(dl_flag), 32'd1);
    toDrivePoint();
    ack = 1'b0;
  endtask

  initial begin
    logic [3:0] det;
    int         ret;

    reset             = 1'b0;
    dl_detect_vec     = '0;
    token_vec         = '0;
    ack               = 1'b0;
    rpt_bus.rpt_ready = 1'b0;
    ret_idx           = -1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkAllZero("reset");
    toDrivePoint();
    reset = 1'b1;

    $display("[TB] ring 0->2->1->0 with backpressure on beat 1");
    tok_q.delete();
    tok_q.push_back(4'b0100);
    tok_q.push_back(4'b0010);
    tok_q.push_back(4'b0001);
    ret_idx = 2;
    applyStimulus(4'b0001, 1'b0, 1, 5, 0, 4'b0000);

    $display("[TB] multiple detects 1010");
    buildTokens(4'b1010, 3, 4);
    applyStimulus(4'b1010, 1'b0, -1, 0, 0, 4'b0000);

    $display("[TB] token never returns");
    buildTokens(4'b0100, -1, TRACE_MAX);
    applyStimulus(4'b0100, 1'b1, -1, 0, 0, 4'b0000);

    $display("[TB] token returns on the final trace cycle");
    buildTokens(4'b1000, TRACE_MAX - 1, TRACE_MAX);
    applyStimulus(4'b1000, 1'b0, -1, 0, 0, 4'b0110);

    $display("[TB] detect held through ack");
    buildTokens(4'b0110, 1, 2);
    applyStimulus(4'b0110, 1'b1, -1, 0, 0, 4'b0000);

    $display("[TB] reset during report");
    tok_q.delete();
    tok_q.push_back(4'b0100);
    tok_q.push_back(4'b0010);
    tok_q.push_back(4'b0001);
    ret_idx = 2;
    applyStimulus(4'b0001, 1'b0, -1, 0, 1, 4'b0000);

    $display("[TB] randomized scenarios");
    for (int s = 0; s < 20; s++) begin
      det = 4'($urandom_range(1, 15));
      ret = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8));
      buildTokens(det, ret, (ret < 0) ? TRACE_MAX : ret + 1);
      applyStimulus(det, 1'b1, -1, 0, 0, 4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
